// File: rtl/inst_prefetch_pkg.sv
// Shared definitions for the instruction prefetch unit and any decode logic
// that needs Y86 icode and length knowledge.
package inst_prefetch_pkg;

  localparam int BYTE_W    = 8;
  localparam int WORD_W    = 32;
  localparam int INSTBUS_W = 48;
  localparam int MAX_LEN   = 6;

  typedef enum logic [3:0] {
    IHALT   = 4'h0,
    INOP    = 4'h1,
    IRRMOVL = 4'h2,
    IIRMOVL = 4'h3,
    IRMMOVL = 4'h4,
    IMRMOVL = 4'h5,
    IOPL    = 4'h6,
    IJXX    = 4'h7,
    ICALL   = 4'h8,
    IRET    = 4'h9,
    IPUSHL  = 4'hA,
    IPOPL   = 4'hB
  } icode_e;

  localparam logic [2:0] LEN_1 = 3'd1;
  localparam logic [2:0] LEN_2 = 3'd2;
  localparam logic [2:0] LEN_5 = 3'd5;
  localparam logic [2:0] LEN_6 = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/inst_len_dec.sv
// Y86 icode to instruction length decoder; unknown icodes decode as one byte
// and raise err so the pipeline can still step past them.
module inst_len_dec
  import inst_prefetch_pkg::*;
(
  input  logic [3:0] icode,
  output logic [2:0] len,
  output logic       err
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    len = LEN_1;
    err = 1'b0;
    case (icode)
      IHALT, INOP, IRET:            len = LEN_1;
      IRRMOVL, IOPL, IPUSHL, IPOPL: len = LEN_2;
      IJXX, ICALL:                  len = LEN_5;
      IIRMOVL, IRMMOVL, IMRMOVL:    len = LEN_6;
      default:                      err = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_prefetch.sv
// Byte-wide prefetcher: streams ROM bytes into a circular queue and presents
// the head Y86 instruction, left-aligned, once all of its bytes are present.
module inst_prefetch
  import inst_prefetch_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = WORD_W,
  parameter int INST_W = INSTBUS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              consume_i,
  output logic [INST_W-1:0] inst_o,
  output logic [2:0]        inst_len_o,
  output logic              inst_valid_o,
  output logic              inst_err_o,
  output logic              rom_req_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [BYTE_W-1:0] rom_data_i,
  input  logic              rom_ack_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, pop_len;
  logic [ADDR_W-1:0] fetch_addr;
  logic [2:0]        head_len;
  logic              head_err, nonempty, push, pop;

  inst_len_dec u_len_dec (
    .icode (mem[rd_ptr][BYTE_W-1 -: 4]),
    .len   (head_len),
    .err   (head_err)
  );

  assign nonempty     = (count != '0);
  assign inst_valid_o = nonempty && (count >= CNT_W'(head_len));
  assign inst_len_o   = nonempty ? head_len : 3'd0;
  assign inst_err_o   = nonempty && head_err;

  // A request stays up while outstanding: space cannot shrink until its ack lands.
  assign rom_req_o  = (state_q == S_RUN) && (count < FULL);
  assign rom_addr_o = fetch_addr;

  always_comb begin
    inst_o = '0;
    if (inst_valid_o) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        if (k < int'(head_len))
          inst_o[INST_W-1-BYTE_W*k -: BYTE_W] = mem[rd_ptr + PTR_W'(k)];
      end
    end
  end

  // Redirect wins over a same-cycle ack or consume.
  assign push    = (state_q == S_RUN) && rom_ack_i && !redirect_i;
  assign pop     = consume_i && inst_valid_o && !redirect_i;
  assign pop_len = pop ? CNT_W'(head_len) : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (redirect_i) state_d = S_RUN;
      S_RUN:   if (redirect_i && rom_req_o && !rom_ack_i) state_d = S_DRAIN;
      S_DRAIN: if (rom_ack_i) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fetch_addr <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_i) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        fetch_addr <= pc_i;
      end else begin
        if (push) begin
          wr_ptr     <= wr_ptr + PTR_W'(1);
          fetch_addr <= fetch_addr + ADDR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(head_len);
        count <= count + CNT_W'(push) - pop_len;
      end
    end
  end

  // NOTE: queue storage is not reset; count and the pointers decide which bytes are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rom_data_i;
  end

endmodule

// File: tb/tb_inst_prefetch.sv
// Randomized bench for inst_prefetch: a byte-queue reference model plus a
// variable-latency ROM responder, with directed scenarios up front.
module tb_inst_prefetch;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        consume_i = 1'b0;
  logic [47:0] inst_o;
  logic [2:0]  inst_len_o;
  logic        inst_valid_o, inst_err_o, rom_req_o;
  logic [31:0] rom_addr_o;
  logic [7:0]  rom_data_i = '0;
  logic        rom_ack_i = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  mq[$];
  logic [31:0] mfetch = '0;
  bit          running = 1'b0;
  bit          discard = 1'b0;

  // ROM responder state
  bit          job_active = 1'b0;
  int          job_wait = 0;
  logic [31:0] job_addr = '0;
  logic [7:0]  script[$];
  int          lat_min = 1;
  int          lat_max = 1;

  inst_prefetch #(.DEPTH(DEPTH), .ADDR_W(32), .INST_W(48)) dut (
    .clk          (clk),
    .rst          (rst),
    .redirect_i   (redirect_i),
    .pc_i         (pc_i),
    .consume_i    (consume_i),
    .inst_o       (inst_o),
    .inst_len_o   (inst_len_o),
    .inst_valid_o (inst_valid_o),
    .inst_err_o   (inst_err_o),
    .rom_req_o    (rom_req_o),
    .rom_addr_o   (rom_addr_o),
    .rom_data_i   (rom_data_i),
    .rom_ack_i    (rom_ack_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 3'd1;
      4'h2, 4'h6, 4'hA, 4'hB: return 3'd2;
      4'h7, 4'h8:             return 3'd5;
      4'h3, 4'h4, 4'h5:       return 3'd6;
      default:                return 3'd1;
    endcase
  endfunction

  function automatic void model_out(output logic [2:0] len, output bit valid,
                                    output bit err, output logic [47:0] inst);
    len = '0; valid = 1'b0; err = 1'b0; inst = '0;
    if (mq.size() != 0) begin
      len   = ref_len(mq[0][7:4]);
      err   = (mq[0][7:4] > 4'hB);
      valid = (mq.size() >= int'(len));
      if (valid)
        for (int k = 0; k < int'(len); k++) inst[47-8*k -: 8] = mq[k];
    end
  endfunction

  // One clock: compare at the negedge, play the ROM, drive inputs, advance the model.
  task automatic cycle(input bit redir, input logic [31:0] pc, input bit cons);
    logic [2:0]  elen;
    bit          evalid, eerr, ereq, ack, in_flight;
    logic [47:0] einst;
    logic [7:0]  data;
    @(negedge clk);
    model_out(elen, evalid, eerr, einst);
    ereq = running && !discard && (mq.size() < DEPTH);
    check("inst_valid", inst_valid_o, evalid);
    check("inst_len", inst_len_o, elen);
    check("inst_err", inst_err_o, eerr);
    check("inst", inst_o, einst);
    check("rom_req", rom_req_o, ereq);
    if (rom_req_o) check("rom_addr", rom_addr_o, mfetch);

    ack  = 1'b0;
    data = 8'($urandom);
    if (job_active) begin
      job_wait--;
      if (job_wait == 0) begin
        ack = 1'b1;
        if (script.size() != 0 && !discard) data = script.pop_front();
      end
    end else if (rom_req_o) begin
      job_active = 1'b1;
      job_addr   = rom_addr_o;
      job_wait   = $urandom_range(lat_max, lat_min);
    end
    in_flight = job_active && !ack;
    if (ack) job_active = 1'b0;

    redirect_i = redir;
    pc_i       = pc;
    consume_i  = cons;
    rom_ack_i  = ack;
    rom_data_i = data;

    if (redir) begin
      mq.delete();
      mfetch  = pc;
      running = 1'b1;
      discard = in_flight;
    end else begin
      if (ack) begin
        if (discard) discard = 1'b0;
        else begin
          mq.push_back(data);
          mfetch++;
        end
      end
      if (cons && evalid)
        for (int k = 0; k < int'(elen); k++) void'(mq.pop_front());
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_size(input int n);
    int guard = 0;
    while (mq.size() < n && guard < 200) begin
      cycle(1'b0, '0, 1'b0);
      guard++;
    end
    if (mq.size() < n) check("fill_timeout", mq.size(), n);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_inst", inst_o, 0);
    check("rst_len", inst_len_o, 0);
    check("rst_valid", inst_valid_o, 0);
    check("rst_err", inst_err_o, 0);
    check("rst_req", rom_req_o, 0);
    check("rst_addr", rom_addr_o, 0);
    rst = 1'b1;
    repeat (2) cycle(1'b0, '0, 1'b0);

    // 6-byte irmovl from 0x100 with 1-cycle acks
    lat_min = 1; lat_max = 1;
    script = '{8'h30, 8'h80, 8'h04, 8'h00, 8'h00, 8'h00};
    cycle(1'b1, 32'h100, 1'b0);
    run_until_size(6);
    settle();
    check("d1_valid", inst_valid_o, 1);
    check("d1_len", inst_len_o, 6);
    check("d1_inst", inst_o, 48'h308004000000);

    // nop; addl then consume both, fetch stalled by a long ack
    script = '{8'h10, 8'h60, 8'h12};
    cycle(1'b1, 32'h180, 1'b0);
    run_until_size(3);
    lat_min = 20; lat_max = 20;
    settle();
    check("d2_inst0", inst_o, 48'h100000000000);
    check("d2_len0", inst_len_o, 1);
    cycle(1'b0, '0, 1'b1);
    settle();
    check("d2_inst1", inst_o, 48'h601200000000);
    check("d2_len1", inst_len_o, 2);
    cycle(1'b0, '0, 1'b1);
    settle();
    check("d2_empty_valid", inst_valid_o, 0);
    check("d2_empty_len", inst_len_o, 0);

    // Fill to DEPTH, request drops, one len-2 consume reopens fetch
    lat_min = 1; lat_max = 1;
    script = '{8'h60, 8'h12, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
    cycle(1'b1, 32'h300, 1'b0);
    run_until_size(8);
    repeat (3) cycle(1'b0, '0, 1'b0);
    settle();
    check("d3_full_req", rom_req_o, 0);
    cycle(1'b0, '0, 1'b1);
    settle();
    check("d3_req_again", rom_req_o, 1);
    check("d3_addr", rom_addr_o, 32'h308);

    // Redirect while the request to 0x104 is outstanding
    lat_min = 3; lat_max = 3;
    cycle(1'b1, 32'h100, 1'b0);
    begin
      int guard = 0;
      while (mfetch != 32'h104 && guard < 100) begin
        cycle(1'b0, '0, 1'b0);
        guard++;
      end
      check("d4_reach_104", mfetch, 32'h104);
      cycle(1'b1, 32'h200, 1'b0);
      guard = 0;
      do begin
        cycle(1'b0, '0, 1'b0);
        settle();
        check("d4_valid_low", inst_valid_o, 0);
        guard++;
      end while (!rom_req_o && guard < 12);
      check("d4_new_addr", rom_addr_o, 32'h200);
    end

    // Invalid icode at head
    lat_min = 1; lat_max = 1;
    script = '{8'hF0};
    cycle(1'b1, 32'h400, 1'b0);
    run_until_size(1);
    settle();
    check("d5_err", inst_err_o, 1);
    check("d5_len", inst_len_o, 1);
    check("d5_valid", inst_valid_o, 1);

    // Randomized traffic: redirects, variable latency, light and heavy consumption
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      bit          r;
      bit          c;
      logic [31:0] pc;
      int          cons_pct;
      cons_pct = ((i / 500) % 2 == 1) ? 15 : 70;
      r  = ($urandom_range(99) < 3);
      c  = ($urandom_range(99) < cons_pct);
      pc = ($urandom_range(3) == 0) ? 32'hFFFF_FFFC : $urandom;
      cycle(r, pc, c);
    end

    // Asynchronous reset mid-fetch
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_inst", inst_o, 0);
    check("arst_len", inst_len_o, 0);
    check("arst_valid", inst_valid_o, 0);
    check("arst_err", inst_err_o, 0);
    check("arst_req", rom_req_o, 0);
    check("arst_addr", rom_addr_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
